stream_oddeven_sort: RTL
========================

Name: stream_oddeven_sort

Overview:
Packet sorter for AXI-Stream-style data. Each packet (up to MAX_LEN beats) is buffered in a register array, sorted by an odd-even transposition network with MAX_LEN/2 compare-exchange cells per cycle, then ejected in order. It supersedes the single-swapper FIFO-loop bubble sorter in the sorting pipeline. It adds a key field narrower than data, runtime ascending/descending mode, early exit when already sorted, and explicit oversize-packet truncation with drain.

Parameters:
DATA_WIDTH, 16, beat width in bits; the payload travels with its key.
KEY_WIDTH, 8, sort key is tdata[KEY_WIDTH-1:0], compared unsigned; 1..DATA_WIDTH.
MAX_LEN, 16, max beats per packet; even, >=2.

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  reset; asynchronous, active-low.
src_tvalid  in  1  input beat valid.
src_tready  out  1  input accept.
src_tdata  in  DATA_WIDTH  input beat.
src_tlast  in  1  last beat of packet.
sort_desc  in  1  0=ascending, 1=descending; sampled on first beat of packet.
dest_tvalid  out  1  output beat valid.
dest_tready  in  1  output accept.
dest_tdata  out  DATA_WIDTH  sorted beat.
dest_tlast  out  1  last sorted beat.
busy  out  1  high in any state other than LOAD-with-zero-beats.
pkt_trunc  out  1  one-cycle pulse when a packet exceeded MAX_LEN.

Behaviour:
- Reset (rst low, async): state=LOAD, len=0, all counters 0, dest_tvalid=0, dest_tlast=0, src_tready=0 while rst low, busy=0, pkt_trunc=0. Array contents are don't-care. A reset mid-packet discards that packet.
- Handshake: a beat transfers when tvalid&&tready. dest_tdata and dest_tlast hold stable while dest_tvalid&&!dest_tready.
- States: LOAD, DRAIN, SORT, EJECT.
- LOAD: src_tready=1. Each accepted beat is written to arr[len], then len++. On the first beat, mode<=sort_desc.
  - Accepted beat with src_tlast -> SORT.
  - Accepted beat with len==MAX_LEN-1 and !src_tlast -> DRAIN, with pkt_trunc pulsed the same cycle.
  - Both conditions at once -> SORT, no trunc.
- DRAIN: src_tready=1. Beats are accepted and discarded. An accepted beat with src_tlast -> SORT.
- SORT: src_tready=0, dest_tvalid=0. Cycle k (k from 0) applies phase parity p=k[0]: cells compare pairs (i,i+1) for i≡p mod 2, with a pair enabled only if i+1<len.
  - Swap condition: ascending swaps when key[i]>key[i+1]; descending swaps when key[i]<key[i+1]. Equal keys never swap, so the sort is stable.
  - Exit to EJECT at the end of cycle k if k+1==len, or if k>=1 and no swap occurred in cycles k and k-1.
  - Worst case is len cycles; an already-sorted packet with len>=2 exits after 2 cycles; len==1 exits after 1 cycle.
- EJECT: dest_tvalid=1, dest_tdata=arr[e], dest_tlast=(e==len-1). e advances on each transfer. The transfer with tlast -> LOAD, clearing len and e. src_tready=0 throughout.
- Latency: the first output beat is valid on the cycle after the last SORT cycle. No input/output overlap between packets (single buffer).
- Counter widths: len, e and k are $clog2(MAX_LEN+1) bits, so len==MAX_LEN never wraps.
- Output registers: dest_* are driven from registered e/len/array through a mux. No combinational path from src_* to dest_*. dest_tready affects only e/state.

Decomposition:
- Package stream_sort_pkg holds the state encoding constants (LOAD=0, DRAIN=1, SORT=2, EJECT=3) and a clog2 helper for counter widths.
- Sub-module sort_cmp_exchange (DATA_WIDTH, KEY_WIDTH): combinational. Inputs a, b, desc, en; outputs lo, hi, swapped. Instantiated MAX_LEN-1 times, one per adjacent pair; the parity/len enable is applied at the instance.

Test Plan:
1. Ascending, keys 3,1,4,1,5 with distinct payloads, tlast on 5th -> output keys 1,1,3,4,5, with the two 1s in input order; tlast only on beat 5; busy low after the final transfer.
2. sort_desc=1, keys 2,9,9,0,7,7,7,1 -> 9,9,7,7,7,2,1,0, payload order stable among equal keys. sort_desc toggled mid-packet has no effect.
3. Pre-sorted 1..8 ascending -> SORT lasts exactly 2 cycles; output identical to input. Reverse-sorted 8..1 -> SORT lasts exactly 8 cycles.
4. MAX_LEN=16, 19-beat packet -> pkt_trunc pulses once on beat 16. Beats 17-19 are accepted and dropped. 16 sorted beats are output with tlast on the 16th. The next 3-beat packet sorts correctly.
5. Single-beat packet key 0x5A -> SORT 1 cycle; one output 0x5A with tlast. Random dest_tready backpressure on test 1 -> identical data; dest_tdata stable while stalled.
6. rst asserted during EJECT (beat 2 of 5) -> dest_tvalid low asynchronously. After release, src_tready=1 in LOAD, and a fresh packet 6,5 outputs 5,6.

Source files
------------

// File: rtl/stream_sort_pkg.sv
// ============================================================================
//  Module   : stream_sort_pkg
//  Purpose  : Shared state encoding and width helper for stream_oddeven_sort.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_sort_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SORT  = 2'd2,
        ST_EJECT = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sort_cmp_exchange.sv
// ============================================================================
//  Module   : sort_cmp_exchange
//  Purpose  : One compare-exchange cell; passes a/b straight through when idle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sort_cmp_exchange #(
    parameter int DATA_WIDTH = 16,
    parameter int KEY_WIDTH  = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  desc,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi,
    output logic                  swapped
);

    logic [KEY_WIDTH-1:0] w_ka;
    logic [KEY_WIDTH-1:0] w_kb;

    assign w_ka = a[KEY_WIDTH-1:0];
    assign w_kb = b[KEY_WIDTH-1:0];

    // Strict comparisons keep equal keys in place, which makes the sort stable.
    assign swapped = en && (desc ? (w_ka < w_kb) : (w_ka > w_kb));
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

`default_nettype wire

// File: rtl/stream_oddeven_sort.sv
// ============================================================================
//  Module   : stream_oddeven_sort
//  Purpose  : Buffers a packet, sorts it with odd-even transposition, ejects it.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_oddeven_sort
    import stream_sort_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int KEY_WIDTH  = 8,
    parameter int MAX_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_tvalid,
    output logic                  src_tready,
    input  logic [DATA_WIDTH-1:0] src_tdata,
    input  logic                  src_tlast,
    input  logic                  sort_desc,
    output logic                  dest_tvalid,
    input  logic                  dest_tready,
    output logic [DATA_WIDTH-1:0] dest_tdata,
    output logic                  dest_tlast,
    output logic                  busy,
    output logic                  pkt_trunc
);

    localparam int            CW         = clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LEN_MAX_M1 = CW'(MAX_LEN - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           len_q, len_d;
    logic [CW-1:0]           e_q, e_d;
    logic [CW-1:0]           k_q, k_d;
    logic                    mode_q, mode_d;
    logic                    swap_prev_q, swap_prev_d;
    logic [DATA_WIDTH-1:0]   arr_q [MAX_LEN];
    logic [DATA_WIDTH-1:0]   arr_d [MAX_LEN];

    logic [DATA_WIDTH-1:0]   w_lo  [MAX_LEN-1];
    logic [DATA_WIDTH-1:0]   w_hi  [MAX_LEN-1];
    logic [DATA_WIDTH-1:0]   w_net [MAX_LEN];
    logic [MAX_LEN-2:0]      w_en;
    logic [MAX_LEN-2:0]      w_swapped;
    logic [DATA_WIDTH-1:0]   w_dout;
    logic                    w_accept;
    logic                    w_any_swap;
    logic                    w_sort_done;
    logic                    w_last_beat;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN - 1; gi++) begin : g_cell
            assign w_en[gi] = (k_q[0] == 1'(gi % 2)) && (CW'(gi + 1) < len_q);
            sort_cmp_exchange #(
                .DATA_WIDTH (DATA_WIDTH),
                .KEY_WIDTH  (KEY_WIDTH)
            ) u_cell (
                .a       (arr_q[gi]),
                .b       (arr_q[gi+1]),
                .desc    (mode_q),
                .en      (w_en[gi]),
                .lo      (w_lo[gi]),
                .hi      (w_hi[gi]),
                .swapped (w_swapped[gi])
            );
        end

        // Idle cells pass through, so each slot can pick lo of its own pair or hi of the left pair.
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_pos
            if (gi == 0) begin : g_first
                assign w_net[gi] = w_lo[gi];
            end else if (gi == MAX_LEN - 1) begin : g_last
                assign w_net[gi] = w_hi[gi-1];
            end else begin : g_mid
                assign w_net[gi] = w_en[gi] ? w_lo[gi] : w_hi[gi-1];
            end
        end
    endgenerate

    assign w_any_swap  = |w_swapped;
    assign w_sort_done = ((k_q + CW'(1)) == len_q) ||
                         ((k_q != '0) && !w_any_swap && !swap_prev_q);
    assign w_last_beat = (e_q == (len_q - CW'(1)));

    assign src_tready  = rst && ((state_q == ST_LOAD) || (state_q == ST_DRAIN));
    assign w_accept    = src_tvalid && src_tready;
    assign pkt_trunc   = w_accept && (state_q == ST_LOAD) && (len_q == LEN_MAX_M1) && !src_tlast;
    assign busy        = !((state_q == ST_LOAD) && (len_q == '0));
    assign dest_tvalid = (state_q == ST_EJECT);
    assign dest_tlast  = dest_tvalid && w_last_beat;
    assign dest_tdata  = w_dout;

    always_comb begin
        w_dout = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (CW'(i) == e_q) w_dout = arr_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        e_d         = e_q;
        k_d         = k_q;
        mode_d      = mode_q;
        swap_prev_d = swap_prev_q;
        arr_d       = arr_q;
        case (state_q)
            ST_LOAD: begin
                if (w_accept) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (CW'(i) == len_q) arr_d[i] = src_tdata;
                    end
                    len_d = len_q + CW'(1);
                    if (len_q == '0) mode_d = sort_desc;
                    if (src_tlast) begin
                        state_d     = ST_SORT;
                        k_d         = '0;
                        swap_prev_d = 1'b0;
                    end else if (len_q == LEN_MAX_M1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_accept && src_tlast) begin
                    state_d     = ST_SORT;
                    k_d         = '0;
                    swap_prev_d = 1'b0;
                end
            end
            ST_SORT: begin
                arr_d       = w_net;
                k_d         = k_q + CW'(1);
                swap_prev_d = w_any_swap;
                if (w_sort_done) begin
                    state_d = ST_EJECT;
                    e_d     = '0;
                end
            end
            ST_EJECT: begin
                if (dest_tready) begin
                    if (w_last_beat) begin
                        state_d = ST_LOAD;
                        len_d   = '0;
                        e_d     = '0;
                    end else begin
                        e_d = e_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_LOAD;
            len_q       <= '0;
            e_q         <= '0;
            k_q         <= '0;
            mode_q      <= 1'b0;
            swap_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            e_q         <= e_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            swap_prev_q <= swap_prev_d;
        end
    end

    // Packet storage needs no reset; contents are qualified by len.
    always_ff @(posedge clk) begin
        arr_q <= arr_d;
    end

endmodule

`default_nettype wire
